// File: rtl/country_sensor_front_end_if.sv
// Signal bundle between the country-road loop sensor and the traffic-light controller side.
// The master drives the raw loop and the light state; the slave is the sensor front end.
interface country_sensor_front_end_if #(
  parameter int QUEUE_W = 4
) ();
  logic               loop_raw;
  logic [2:0]         cntry;
  logic               x;
  logic [QUEUE_W-1:0] queue_count;
  logic               car_arrived;
  logic               overflow;
  logic               light_err;

  modport master (
    output loop_raw, cntry,
    input  x, queue_count, car_arrived, overflow, light_err
  );

  modport slave (
    input  loop_raw, cntry,
    output x, queue_count, car_arrived, overflow, light_err
  );
endinterface

// File: rtl/country_sensor_front_end.sv
// Country-road car detector: synchronises and debounces the loop, counts arrivals,
// retires cars after a run of country green, and raises x while any car is waiting.
module country_sensor_front_end #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int QUEUE_W         = 4,
  parameter int PASS_CYCLES     = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  country_sensor_front_end_if.slave bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PC_W = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;
  localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PC_W-1:0]    PC_LAST = PC_W'(PASS_CYCLES - 1);
  localparam logic [QUEUE_W-1:0] Q_MAX   = '1;

  logic               sync_1;
  logic               loop_s;
  logic               loop_db;
  logic [DB_W-1:0]    db_cnt;
  logic [PC_W-1:0]    pass_cnt;
  logic [QUEUE_W-1:0] count;
  logic               arrived_q;
  logic               overflow_q;
  logic               light_err_q;

  logic db_differ;
  logic db_toggle;
  logic arrive;
  logic pass_active;
  logic depart;
  logic cntry_valid;

  always_comb begin
    db_differ   = (loop_s != loop_db);
    db_toggle   = db_differ && (db_cnt == DB_LAST);
    arrive      = db_toggle && !loop_db;
    pass_active = (bus.cntry == 3'b100) && (count != '0);
    depart      = pass_active && (pass_cnt == PC_LAST);
    cntry_valid = (bus.cntry == 3'b001) || (bus.cntry == 3'b010) || (bus.cntry == 3'b100);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1      <= 1'b0;
      loop_s      <= 1'b0;
      loop_db     <= 1'b0;
      db_cnt      <= '0;
      pass_cnt    <= '0;
      count       <= '0;
      arrived_q   <= 1'b0;
      overflow_q  <= 1'b0;
      light_err_q <= 1'b0;
    end else begin
      sync_1 <= bus.loop_raw;
      loop_s <= sync_1;

      if (db_toggle) begin
        loop_db <= ~loop_db;
        db_cnt  <= '0;
      end else if (db_differ) begin
        db_cnt <= db_cnt + 1'b1;
      end else begin
        db_cnt <= '0;
      end

      arrived_q <= arrive;

      // Any break in green-with-cars restarts the pass timing from scratch.
      if (pass_active && !depart) begin
        pass_cnt <= pass_cnt + 1'b1;
      end else begin
        pass_cnt <= '0;
      end

      // A simultaneous arrival and departure cancel out, so no overflow is flagged.
      case ({arrive, depart})
        2'b10: begin
          if (count == Q_MAX) begin
            overflow_q <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (!cntry_valid) begin
        light_err_q <= 1'b1;
      end
    end
  end

  assign bus.queue_count = count;
  assign bus.x           = (count != '0);
  assign bus.car_arrived = arrived_q;
  assign bus.overflow    = overflow_q;
  assign bus.light_err   = light_err_q;

endmodule

// File: tb/tb_country_sensor_front_end.sv
// Directed and randomised checks of the country-road sensor front end against a
// history-based behavioural model of debounce, arrival counting and green-pass retirement.
module tb_country_sensor_front_end;

  localparam int DEB  = 4;
  localparam int QW   = 4;
  localparam int PASS = 3;
  localparam int QMAX = (1 << QW) - 1;

  localparam logic [2:0] RED = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b100;

  logic clk;
  logic reset;

  country_sensor_front_end_if #(.QUEUE_W(QW)) bus ();

  country_sensor_front_end #(
    .DEBOUNCE_CYCLES(DEB),
    .QUEUE_W        (QW),
    .PASS_CYCLES    (PASS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: loop_s is the raw input seen two edges late; the debounced level
  // flips once the last DEB loop_s samples all disagree with it.
  int m_raw_q[$];
  int m_ls_hist[$];
  int m_db;
  int m_cars;
  int m_ovf;
  int m_lerr;
  int m_green_run;
  int m_arrived;

  task automatic model_reset();
    m_raw_q     = {0, 0};
    m_ls_hist   = {};
    m_db        = 0;
    m_cars      = 0;
    m_ovf       = 0;
    m_lerr      = 0;
    m_green_run = 0;
    m_arrived   = 0;
  endtask

  task automatic model_edge(input logic raw, input logic [2:0] c);
    int ls;
    int flip;
    int arr;
    int dep;
    ls = m_raw_q[0];
    void'(m_raw_q.pop_front());
    m_raw_q.push_back(int'(raw));
    m_ls_hist.push_back(ls);
    if (m_ls_hist.size() > DEB) void'(m_ls_hist.pop_front());
    flip = (m_ls_hist.size() == DEB) ? 1 : 0;
    foreach (m_ls_hist[i]) if (m_ls_hist[i] == m_db) flip = 0;
    arr = (flip == 1 && m_db == 0) ? 1 : 0;
    if (flip == 1) begin
      m_db = 1 - m_db;
      m_ls_hist = {};
    end
    dep = 0;
    if (c == GRN && m_cars > 0) begin
      m_green_run++;
      if (m_green_run == PASS) begin
        dep = 1;
        m_green_run = 0;
      end
    end else begin
      m_green_run = 0;
    end
    if (arr == 1 && dep == 0) begin
      if (m_cars == QMAX) m_ovf = 1;
      else m_cars++;
    end else if (dep == 1 && arr == 0) begin
      m_cars--;
    end
    if (!(c == RED || c == YEL || c == GRN)) m_lerr = 1;
    m_arrived = arr;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("queue_count", 32'(bus.queue_count), 32'(m_cars));
    chk("x", 32'(bus.x), 32'(m_cars != 0));
    chk("car_arrived", 32'(bus.car_arrived), 32'(m_arrived));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("light_err", 32'(bus.light_err), 32'(m_lerr));
  endtask

  task automatic step(input logic raw, input logic [2:0] c);
    bus.loop_raw = raw;
    bus.cntry    = c;
    @(posedge clk);
    model_edge(raw, c);
    #1;
    check_model();
  endtask

  // Asserted mid-cycle so the asynchronous clear is observed before any clock edge.
  task automatic do_reset();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_queue_count", 32'(bus.queue_count), 32'd0);
    chk("rst_x", 32'(bus.x), 32'd0);
    chk("rst_car_arrived", 32'(bus.car_arrived), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_light_err", 32'(bus.light_err), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic arrive_car();
    repeat (5) step(1'b1, RED);
    repeat (7) step(1'b0, RED);
  endtask

  // Raw goes high at edge k and green starts at k+3, so arrival and departure share edge k+5.
  task automatic arrive_with_depart();
    repeat (3) step(1'b1, RED);
    repeat (3) step(1'b1, GRN);
  endtask

  initial begin
    int run_len;
    logic rnd_raw;
    logic [2:0] rnd_c;

    reset        = 1'b0;
    bus.loop_raw = 1'b0;
    bus.cntry    = RED;
    model_reset();
    do_reset();
    repeat (4) step(1'b0, RED);

    // Short glitch is ignored; a full DEB-cycle pulse counts.
    repeat (3) step(1'b1, RED);
    repeat (8) step(1'b0, RED);
    chk("glitch3_count", 32'(bus.queue_count), 32'd0);
    chk("glitch3_x", 32'(bus.x), 32'd0);
    repeat (4) step(1'b1, RED);
    repeat (8) step(1'b0, RED);
    chk("pulse4_count", 32'(bus.queue_count), 32'd1);

    // Arrival latency: raw sampled high at edge k, pulse after edge k+5.
    repeat (5) step(1'b1, RED);
    chk("latency_early", 32'(bus.car_arrived), 32'd0);
    step(1'b1, RED);
    chk("latency_pulse", 32'(bus.car_arrived), 32'd1);
    chk("latency_count", 32'(bus.queue_count), 32'd2);
    chk("latency_x", 32'(bus.x), 32'd1);
    step(1'b1, RED);
    chk("pulse_single", 32'(bus.car_arrived), 32'd0);
    repeat (8) step(1'b1, RED);
    chk("parked_once", 32'(bus.queue_count), 32'd2);
    repeat (8) step(1'b0, RED);

    // Interrupted green restarts the pass count; then two full passes empty the queue.
    repeat (2) step(1'b0, GRN);
    step(1'b0, YEL);
    chk("pass_interrupt", 32'(bus.queue_count), 32'd2);
    repeat (2) step(1'b0, GRN);
    chk("pass_restart", 32'(bus.queue_count), 32'd2);
    step(1'b0, GRN);
    chk("pass_one", 32'(bus.queue_count), 32'd1);
    repeat (3) step(1'b0, GRN);
    chk("pass_empty", 32'(bus.queue_count), 32'd0);
    chk("pass_empty_x", 32'(bus.x), 32'd0);
    repeat (4) step(1'b0, GRN);
    step(1'b0, RED);

    arrive_car();
    arrive_car();
    arrive_with_depart();
    chk("coinc2_count", 32'(bus.queue_count), 32'd2);
    chk("coinc2_arrived", 32'(bus.car_arrived), 32'd1);
    repeat (8) step(1'b0, RED);

    repeat (13) arrive_car();
    chk("sat_full", 32'(bus.queue_count), 32'(QMAX));
    chk("sat_no_ovf", 32'(bus.overflow), 32'd0);
    arrive_car();
    chk("sat_hold", 32'(bus.queue_count), 32'(QMAX));
    chk("sat_ovf", 32'(bus.overflow), 32'd1);
    arrive_with_depart();
    chk("sat_coinc_count", 32'(bus.queue_count), 32'(QMAX));
    chk("sat_coinc_ovf", 32'(bus.overflow), 32'd1);
    chk("sat_coinc_arrived", 32'(bus.car_arrived), 32'd1);
    repeat (8) step(1'b0, RED);

    step(1'b0, 3'b011);
    chk("light_err_set", 32'(bus.light_err), 32'd1);
    repeat (3) step(1'b0, RED);
    chk("light_err_sticky", 32'(bus.light_err), 32'd1);

    // Reset during a partial pass with loop held high through release.
    do_reset();
    repeat (3) arrive_car();
    chk("pre_reset_count", 32'(bus.queue_count), 32'd3);
    repeat (2) step(1'b0, GRN);
    bus.loop_raw = 1'b1;
    do_reset();
    repeat (DEB + 1) step(1'b1, RED);
    chk("post_rst_early", 32'(bus.queue_count), 32'd0);
    step(1'b1, RED);
    chk("post_rst_arrive", 32'(bus.car_arrived), 32'd1);
    chk("post_rst_count", 32'(bus.queue_count), 32'd1);
    repeat (10) step(1'b1, RED);
    chk("post_rst_once", 32'(bus.queue_count), 32'd1);

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 120; i++) begin
      rnd_raw = 1'($urandom_range(0, 1));
      run_len = int'($urandom_range(1, 9));
      case ($urandom_range(0, 9))
        0, 1, 2:    rnd_c = RED;
        3:          rnd_c = YEL;
        4, 5, 6, 7: rnd_c = GRN;
        8:          rnd_c = (i % 3 == 0) ? GRN : RED;
        default:    rnd_c = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(0, 7)) : YEL;
      endcase
      for (int j = 0; j < run_len; j++) step(rnd_raw, rnd_c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/country_sensor_front_end.md
Name: country_sensor_front_end

Overview:
- Country-road vehicle detector that generates the car-waiting request `x` for the highway/country traffic-light controller.
- Synchronises and debounces the raw inductive-loop input and counts arriving cars.
- Watches the controller's country light to retire cars as they pass on green.
- Holds `x` high while any counted car is still waiting.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised loop must disagree with the debounced level before that level toggles (>=1)
QUEUE_W, 4, width of the waiting-car counter; saturates at 2^QUEUE_W-1
PASS_CYCLES, 3, cycles of country green with queue>0 needed to retire one car (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
loop_raw  input  1  raw loop detector, asynchronous to clk, may bounce
cntry  input  3  country light from controller, one-hot: red=3'b001, yellow=3'b010, green=3'b100
x  output  1  car-waiting request to controller
queue_count  output  QUEUE_W  number of cars currently counted as waiting
car_arrived  output  1  one-cycle pulse per debounced arrival
overflow  output  1  sticky: an arrival was dropped at saturation
light_err  output  1  sticky: `cntry` was sampled as a non-one-hot value

Behaviour:
- Reset values:
  - Synchroniser flops, `loop_db`, debounce counter and pass counter are all 0.
  - `x`, `queue_count`, `car_arrived`, `overflow` and `light_err` are all 0.
- Synchroniser: two-flop chain on `loop_raw`; its output is `loop_s`.
- Debounce:
  - The counter increments on each edge where `loop_s != loop_db`.
  - It clears on any edge where they are equal.
  - On the edge where `loop_s != loop_db` and the counter is DEBOUNCE_CYCLES-1, `loop_db` toggles and the counter clears.
  - Disagreement lasting fewer than DEBOUNCE_CYCLES cycles is ignored.
- Arrival:
  - On the edge where `loop_db` goes 0->1, `car_arrived` is 1 for exactly one cycle and the arrival is applied to the queue at that same edge.
  - A 1->0 transition of `loop_db` has no queue effect.
  - A car parked on the loop therefore counts once.
- Latency: if `loop_raw` is high from before edge k, `loop_db`, `car_arrived` and `x` go high after edge k+1+DEBOUNCE_CYCLES (k+5 at default).
- Departure:
  - The pass counter increments on each edge where `cntry==3'b100` and `queue_count>0`.
  - On the edge where it is PASS_CYCLES-1, a depart event occurs and the counter clears.
  - The counter clears on any edge where `cntry!=3'b100` or `queue_count==0`.
- Queue update, per edge:
  - Arrival only, count < max: increment.
  - Arrival only, count == max: hold and set `overflow`.
  - Depart only: decrement. Depart is never raised at 0.
  - Arrival and depart together: hold, with no overflow even at max. `car_arrived` still pulses.
  - Neither: hold.
- `x` = (`queue_count != 0`), driven from the registered count; it is not gated by the light state.
- `light_err`:
  - Set on any edge where `cntry` is not one of 001, 010, 100 (this includes 000).
  - An invalid value also clears the pass counter.
  - Cleared only by reset.
- Reset mid-operation:
  - Everything clears immediately, even with a partially elapsed pass count; pending cars are discarded.
  - If `loop_raw` is held high through reset, one fresh arrival is counted DEBOUNCE_CYCLES+2 edges after reset release.

Test Plan:
- Reset, `cntry`=001, `loop_raw` steps 0->1 before edge 10 -> `car_arrived` pulses after edge 15; `queue_count`=1; `x`=1.
- `loop_raw` glitches high for 3 cycles, then low -> no `car_arrived`; `queue_count`=0; `x`=0. Repeat with 4 cycles high -> one arrival.
- `queue_count`=1, `cntry` goes 100 from edge 20 -> `queue_count`=0 and `x`=0 after edge 22. `cntry` back to 010 before edge 22 -> count stays 1 and the pass counter restarts.
- Saturation: 15 arrivals then one more -> `queue_count`=15 and `overflow`=1. Next arrival coinciding with a depart -> `queue_count` stays 15, `overflow` remains 1.
- Arrival pulse on the same edge as a depart with `queue_count`=2 -> `queue_count`=2, `car_arrived`=1.
- `cntry`=3'b011 for one cycle -> `light_err`=1 and stays set. Assert reset mid-pass with `queue_count`=3 -> all outputs 0 immediately. `loop_raw` held high through release -> exactly one arrival after DEBOUNCE_CYCLES+2 edges.
